// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared encodings, FSM state type and size helper for
// the data-memory responder and its load aligner.
package dmem_responder_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Number of bytes touched by an access; reserved size reports 4 but is
  // always flagged as an error by the responder.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  size_bytes = 3'd1;
      SIZE_H:  size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_load_align.sv
// dmem_load_align: turns four little-endian fetched bytes into a load result,
// sign- or zero-extended according to size and the unsigned flag.
module dmem_load_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] bytes_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  // Extension select; word loads ignore the unsigned flag.
  always_comb begin
    data_o = 32'h0;
    case (size_i)
      SIZE_B:  data_o = {{24{~unsigned_i & bytes_i[7]}}, bytes_i[7:0]};
      SIZE_H:  data_o = {{16{~unsigned_i & bytes_i[15]}}, bytes_i[15:0]};
      SIZE_W:  data_o = bytes_i;
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target with valid/ready request and
// response channels, byte-lane stores, extended loads and fault reporting.
// Optional build macro: DMEM_RESPONDER_MISALIGN_ERR_EN (misaligned half/word
// accesses fault instead of being split across consecutive bytes).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | req_ready high, waiting for a request
// ST_WAIT | request latched; array access cycle plus WAIT_CYCLES waits
// ST_RESP | response presented, held until resp_ready
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int MEM_NBYTE   = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(MEM_NBYTE);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;

  logic [7:0]        mem_q [MEM_NBYTE];

  logic [2:0]        nbytes;
  logic [ADDR_W:0]   end_addr;
  logic              range_err;
  logic              size_err;
  logic              mis_err;
  logic              acc_err;
  logic              done;
  logic              wr_en;
  logic [AW-1:0]     idx [4];
  logic [3:0]        lane_en;
  logic [31:0]       fetch;
  logic [31:0]       load_data;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Fault decode on the latched request.
  always_comb begin
    nbytes    = size_bytes(size_q);
    end_addr  = {1'b0, addr_q} + {{(ADDR_W-2){1'b0}}, nbytes};
    range_err = end_addr > (ADDR_W+1)'(MEM_NBYTE);
    size_err  = (size_q == 2'b11);
`ifdef DMEM_RESPONDER_MISALIGN_ERR_EN
    mis_err   = ((size_q == SIZE_H) && addr_q[0]) ||
                ((size_q == SIZE_W) && (addr_q[1:0] != 2'b00));
`else
    mis_err   = 1'b0;
`endif
    acc_err   = range_err | size_err | mis_err;
  end

  assign done  = (state_q == ST_WAIT) && (cnt_q == 4'(WAIT_CYCLES));
  assign wr_en = done && we_q && !acc_err;

  // Per-lane byte index and fetch; out-of-range indices wrap harmlessly
  // because any such access is already faulted.
  always_comb begin
    fetch   = 32'h0;
    lane_en = 4'h0;
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_RESPONDER_MISALIGN_ERR_EN
      idx[k] = {addr_q[AW-1:2], 2'(addr_q[1:0] + 2'(k))};
`else
      idx[k] = addr_q[AW-1:0] + AW'(k);
`endif
      lane_en[k]      = (3'(k) < nbytes);
      fetch[8*k +: 8] = mem_q[idx[k]];
    end
  end

  dmem_load_align u_align (
    .bytes_i    (fetch),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  // Store commit on the edge that moves WAIT into RESP.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem_q[idx[k]] <= wdata_q[8*k +: 8];
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      size_q       <= SIZE_B;
      uns_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (done) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= acc_err;
            resp_rdata_q <= (we_q || acc_err) ? 32'h0 : load_data;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder with two wait states.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  always #5 clk = ~clk;

  dmem_responder #(
    .MEM_NBYTE   (1024),
    .WAIT_CYCLES (2),
    .ADDR_W      (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction: request, wait for response, retire it.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic uns,
                      output logic [31:0] rdo, output logic ero, output int lato);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lato = 0;
    while (!resp_valid && lato < 50) begin
      @(posedge clk);
      #1 lato++;
    end
    rdo = resp_rdata;
    ero = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_size = 2'b00; req_unsigned = 1'b0; resp_ready = 1'b0;
    #23;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Word store, latency accept+3, then word readback.
    xact(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd3);
    chk("sw_err", 32'(er), 32'h0);
    chk("sw_rdata", rd, 32'h0);
    xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(er), 32'h0);
    chk("lw_lat", 32'(lat), 32'd3);

    // Byte/half extension.
    xact(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, rd, er, lat);
    chk("lb", rd, 32'hFFFFFFEF);
    xact(1'b0, 32'h10, 32'h0, 2'b00, 1'b1, rd, er, lat);
    chk("lbu", rd, 32'h000000EF);
    xact(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, rd, er, lat);
    chk("lh", rd, 32'hFFFFDEAD);
    xact(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, rd, er, lat);
    chk("lhu", rd, 32'h0000DEAD);
    xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b1, rd, er, lat);
    chk("lw_uns_ignored", rd, 32'hDEADBEEF);

    // Partial stores.
    xact(1'b1, 32'h11, 32'hAAAAAA55, 2'b00, 1'b0, rd, er, lat);
    xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("sb_merge", rd, 32'hDEAD55EF);
    xact(1'b1, 32'h12, 32'hBBBB1234, 2'b01, 1'b0, rd, er, lat);
    xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("sh_merge", rd, 32'h123455EF);

    // Backpressure: response held 5 cycles while a store request waits.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clk);
    #1 req_we = 1'b1; req_wdata = 32'hFFFFFFFF;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(resp_valid), 32'h1);
      chk("bp_rdata", resp_rdata, 32'h123455EF);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0; req_valid = 1'b0;
    chk("bp_retire_valid", 32'(resp_valid), 32'h0);
    chk("bp_retire_ready", 32'(req_ready), 32'h1);
    xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("bp_no_write", rd, 32'h123455EF);

    // Range and size errors, plus the last legal word.
    xact(1'b0, 32'd1022, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("oor_err", 32'(er), 32'h1);
    chk("oor_rdata", rd, 32'h0);
    xact(1'b0, 32'h0, 32'h0, 2'b11, 1'b0, rd, er, lat);
    chk("rsv_err", 32'(er), 32'h1);
    xact(1'b1, 32'h3FC, 32'hA5A50F0F, 2'b10, 1'b0, rd, er, lat);
    chk("edge_sw_err", 32'(er), 32'h0);
    xact(1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("edge_lw", rd, 32'hA5A50F0F);
    xact(1'b0, 32'h3FF, 32'h0, 2'b01, 1'b0, rd, er, lat);
    chk("edge_lh_err", 32'(er), 32'h1);
    xact(1'b0, 32'h3FF, 32'h0, 2'b00, 1'b1, rd, er, lat);
    chk("edge_lbu", rd, 32'h000000A5);
    xact(1'b0, 32'h10000010, 32'h0, 2'b00, 1'b0, rd, er, lat);
    chk("high_addr_err", 32'(er), 32'h1);

    // Misaligned word store.
    xact(1'b1, 32'h13, 32'h11223344, 2'b10, 1'b0, rd, er, lat);
`ifdef DMEM_RESPONDER_MISALIGN_ERR_EN
    chk("mis_sw_err", 32'(er), 32'h1);
    xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("mis_lw_unchanged", rd, 32'h123455EF);
`else
    chk("mis_sw_err", 32'(er), 32'h0);
    xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("mis_lw_word0", rd, 32'h443455EF);
    xact(1'b0, 32'h13, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("mis_lw_cross", rd, 32'h11223344);
    xact(1'b0, 32'h15, 32'h0, 2'b01, 1'b0, rd, er, lat);
    chk("mis_lh_cross", rd, 32'h00001122);
`endif

    // Reset during WAIT abandons the store.
    xact(1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0BADBEEF;
    req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("pre_rst_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", 32'(req_ready), 32'h1);
    chk("async_rst_valid", 32'(resp_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    xact(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lat);
    chk("rst_abandon", rd, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
